// File: rtl/run_length_detector.sv
// Serial run detector: flags RUN_LEN identical sampled bits of a selectable polarity,
// with overlapping or restart-after-hit operation and a saturating hit counter.
module run_length_detector #(
  parameter int unsigned RUN_LEN = 3,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned LEN_W  = $clog2(RUN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             x,
  input  logic [1:0]       mode,
  input  logic             overlap,
  output logic             found,
  output logic             found_val,
  output logic [LEN_W-1:0] run_cnt,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             sat
);

  typedef enum logic [0:0] {StIdle, StRun} state_t;

  localparam logic [LEN_W-1:0] LenMax = LEN_W'(RUN_LEN);
  localparam logic [LEN_W-1:0] LenPre = LEN_W'(RUN_LEN - 1);

  state_t state_q;
  logic   last_q;
  logic   mode_ok;
  logic   len_hit;
  logic   hit;

  always_comb begin
    mode_ok = 1'b0;
    unique case (mode)
      2'b00:   mode_ok = x;
      2'b01:   mode_ok = ~x;
      2'b10:   mode_ok = 1'b1;
      default: mode_ok = 1'b0;
    endcase
    len_hit = (run_cnt == LenPre) || (overlap && (run_cnt == LenMax));
    hit     = (state_q == StRun) && (x == last_q) && len_hit && mode_ok;
  end

  assign sat = &hit_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      last_q    <= 1'b0;
      found     <= 1'b0;
      found_val <= 1'b0;
      run_cnt   <= '0;
      hit_cnt   <= '0;
    end else if (clear) begin
      state_q   <= StIdle;
      last_q    <= 1'b0;
      found     <= 1'b0;
      found_val <= 1'b0;
      run_cnt   <= '0;
      hit_cnt   <= '0;
    end else if (!en) begin
      // Idle cycles keep the run alive; only the hit pulse is dropped.
      found     <= 1'b0;
      found_val <= 1'b0;
    end else begin
      found     <= hit;
      found_val <= hit & x;
      if (hit && !sat) hit_cnt <= hit_cnt + 1'b1;
      case (state_q)
        StIdle: begin
          last_q  <= x;
          run_cnt <= LEN_W'(1);
          state_q <= StRun;
        end
        StRun: begin
          if (x != last_q) begin
            last_q  <= x;
            run_cnt <= LEN_W'(1);
          end else if (hit && !overlap) begin
            state_q <= StIdle;
            run_cnt <= '0;
          end else if (run_cnt != LenMax) begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench for run_length_detector (RUN_LEN=3, CNT_W=2); a queue-based
// scoreboard decouples the stimulus driver from the output monitor.
module tb_run_length_detector;

  localparam int unsigned RunLen = 3;
  localparam int unsigned CntW   = 2;
  localparam int unsigned LenW   = $clog2(RunLen + 1);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            clear = 1'b0;
  logic            en = 1'b0;
  logic            x = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic            overlap = 1'b0;
  logic            found;
  logic            found_val;
  logic [LenW-1:0] run_cnt;
  logic [CntW-1:0] hit_cnt;
  logic            sat;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] exp_q[$];
  string      name_q[$];

  run_length_detector #(
    .RUN_LEN(RunLen),
    .CNT_W  (CntW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .en       (en),
    .x        (x),
    .mode     (mode),
    .overlap  (overlap),
    .found    (found),
    .found_val(found_val),
    .run_cnt  (run_cnt),
    .hit_cnt  (hit_cnt),
    .sat      (sat)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {found, found_val, run_cnt, hit_cnt, sat};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got {found,val,run,hit,sat}=%b required %b", name, got, want);
    end
  endtask

  // One sampling edge; the expected outputs after that edge go to the scoreboard.
  task automatic step(input string name, input logic c, input logic e, input logic xi,
                      input logic f, input logic fv, input logic [1:0] rc,
                      input logic [1:0] hc);
    @(negedge clk);
    clear = c;
    en    = e;
    x     = xi;
    @(posedge clk);
    exp_q.push_back({f, fv, rc, hc, (hc == 2'd3)});
    name_q.push_back(name);
    #1;
    en    = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_clear(input string name);
    step(name, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  // Monitor: every edge that had stimulus is compared at the following negedge.
  initial begin
    logic [6:0] e;
    string      nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, outs(), e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_state", outs(), 7'b0);
    @(negedge clk);
    reset = 1'b1;

    // 1: ones, overlapping
    mode = 2'b00; overlap = 1'b1;
    step("t1_e1", 0, 1, 1, 0, 0, 2'd1, 2'd0);
    step("t1_e2", 0, 1, 1, 0, 0, 2'd2, 2'd0);
    step("t1_e3", 0, 1, 1, 1, 1, 2'd3, 2'd1);
    step("t1_e4", 0, 1, 1, 1, 1, 2'd3, 2'd2);
    step("t1_e5", 0, 1, 0, 0, 0, 2'd1, 2'd2);
    do_clear("t1_clr");

    // 2: ones, non-overlapping
    overlap = 1'b0;
    step("t2_e1", 0, 1, 1, 0, 0, 2'd1, 2'd0);
    step("t2_e2", 0, 1, 1, 0, 0, 2'd2, 2'd0);
    step("t2_e3", 0, 1, 1, 1, 1, 2'd0, 2'd1);
    step("t2_e4", 0, 1, 1, 0, 0, 2'd1, 2'd1);
    step("t2_e5", 0, 1, 1, 0, 0, 2'd2, 2'd1);
    step("t2_e6", 0, 1, 1, 1, 1, 2'd0, 2'd2);
    do_clear("t2_clr");

    // 3: either polarity, non-overlapping
    mode = 2'b10;
    step("t3_e1", 0, 1, 0, 0, 0, 2'd1, 2'd0);
    step("t3_e2", 0, 1, 0, 0, 0, 2'd2, 2'd0);
    step("t3_e3", 0, 1, 0, 1, 0, 2'd0, 2'd1);
    step("t3_e4", 0, 1, 1, 0, 0, 2'd1, 2'd1);
    step("t3_e5", 0, 1, 1, 0, 0, 2'd2, 2'd1);
    step("t3_e6", 0, 1, 1, 1, 1, 2'd0, 2'd2);
    do_clear("t3_clr");

    // 4: zero run under ones mode saturates, then switching to zeros hits
    mode = 2'b00; overlap = 1'b1;
    step("t4_e1", 0, 1, 0, 0, 0, 2'd1, 2'd0);
    step("t4_e2", 0, 1, 0, 0, 0, 2'd2, 2'd0);
    step("t4_e3", 0, 1, 0, 0, 0, 2'd3, 2'd0);
    step("t4_e4", 0, 1, 0, 0, 0, 2'd3, 2'd0);
    mode = 2'b01;
    step("t4_e5", 0, 1, 0, 1, 0, 2'd3, 2'd1);
    do_clear("t4_clr");

    // 5: hit counter saturation and clear
    mode = 2'b00;
    step("t5_e1", 0, 1, 1, 0, 0, 2'd1, 2'd0);
    step("t5_e2", 0, 1, 1, 0, 0, 2'd2, 2'd0);
    step("t5_e3", 0, 1, 1, 1, 1, 2'd3, 2'd1);
    step("t5_e4", 0, 1, 1, 1, 1, 2'd3, 2'd2);
    step("t5_e5", 0, 1, 1, 1, 1, 2'd3, 2'd3);
    step("t5_e6", 0, 1, 1, 1, 1, 2'd3, 2'd3);
    step("t5_e7", 0, 1, 1, 1, 1, 2'd3, 2'd3);
    do_clear("t5_clr");

    // 6: enable gaps keep the run; async reset discards a partial run
    step("t6_e1",  0, 1, 1, 0, 0, 2'd1, 2'd0);
    step("t6_e2",  0, 1, 1, 0, 0, 2'd2, 2'd0);
    step("t6_gap1", 0, 0, 0, 0, 0, 2'd2, 2'd0);
    step("t6_gap2", 0, 0, 0, 0, 0, 2'd2, 2'd0);
    step("t6_e3",  0, 1, 1, 1, 1, 2'd3, 2'd1);
    step("t6_off", 0, 0, 1, 0, 0, 2'd3, 2'd1);
    do_clear("t6_clr");
    step("t6_p1", 0, 1, 1, 0, 0, 2'd1, 2'd0);
    step("t6_p2", 0, 1, 1, 0, 0, 2'd2, 2'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("t6_async_rst", outs(), 7'b0);
    @(negedge clk);
    reset = 1'b1;
    step("t6_r1", 0, 1, 1, 0, 0, 2'd1, 2'd0);
    step("t6_r2", 0, 1, 1, 0, 0, 2'd2, 2'd0);
    step("t6_r3", 0, 1, 1, 1, 1, 2'd3, 2'd1);

    // detection off never hits
    mode = 2'b11;
    step("off_e1", 0, 1, 1, 0, 0, 2'd3, 2'd1);

    repeat (3) @(negedge clk);
    check("drain", {6'b0, exp_q.size() == 0}, 7'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
